// File: rtl/serial_magnitude_comparator.sv
// Bit-serial unsigned magnitude comparator: accepts a WIDTH-bit operand pair, scans it MSB-first
// one bit per clock and returns one-hot greater/lesser/equal flags over a valid/ready handshake.
module serial_magnitude_comparator #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned EARLY_EXIT = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             data_a,
  input  logic [WIDTH-1:0]             data_b,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         greater,
  output logic                         lesser,
  output logic                         equal,
  output logic                         busy,
  output logic [$clog2(WIDTH+1)-1:0]   cycles
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d, cycles_q, cycles_d;
  logic             gt_q, gt_d, lt_q, lt_d;
  logic             greater_q, greater_d, lesser_q, lesser_d, equal_q, equal_d;
  logic             out_valid_q, out_valid_d;
  logic             a_bit, b_bit, gt_n, lt_n, last;

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    cnt_d       = cnt_q;
    cycles_d    = cycles_q;
    gt_d        = gt_q;
    lt_d        = lt_q;
    greater_d   = greater_q;
    lesser_d    = lesser_q;
    equal_d     = equal_q;
    out_valid_d = out_valid_q;

    a_bit = a_q[WIDTH-1];
    b_bit = b_q[WIDTH-1];
    // Once a decision is latched, later bits cannot override it.
    gt_n  = gt_q | (~lt_q & a_bit & ~b_bit);
    lt_n  = lt_q | (~gt_q & ~a_bit & b_bit);
    last  = (cnt_q == '0) || ((EARLY_EXIT != 0) && (gt_n || lt_n));

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d      = data_a;
          b_d      = data_b;
          cycles_d = '0;
          cnt_d    = CW'(WIDTH - 1);
          gt_d     = 1'b0;
          lt_d     = 1'b0;
          state_d  = StScan;
        end
      end
      StScan: begin
        cycles_d = cycles_q + CW'(1);
        a_d      = a_q << 1;
        b_d      = b_q << 1;
        gt_d     = gt_n;
        lt_d     = lt_n;
        if (last) begin
          greater_d   = gt_n;
          lesser_d    = lt_n;
          equal_d     = ~(gt_n | lt_n);
          out_valid_d = 1'b1;
          state_d     = StDone;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      StDone: begin
        if (out_ready) begin
          greater_d   = 1'b0;
          lesser_d    = 1'b0;
          equal_d     = 1'b0;
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      cycles_q    <= '0;
      gt_q        <= 1'b0;
      lt_q        <= 1'b0;
      greater_q   <= 1'b0;
      lesser_q    <= 1'b0;
      equal_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cnt_q       <= cnt_d;
      cycles_q    <= cycles_d;
      gt_q        <= gt_d;
      lt_q        <= lt_d;
      greater_q   <= greater_d;
      lesser_q    <= lesser_d;
      equal_q     <= equal_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign out_valid = out_valid_q;
  assign greater   = greater_q;
  assign lesser    = lesser_q;
  assign equal     = equal_q;
  assign cycles    = cycles_q;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Directed and exhaustive checks of serial_magnitude_comparator across four configurations
// (W4 early-exit, W4 full-scan, W8 full-scan, W1) sharing one clock and reset.
module tb_serial_magnitude_comparator;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0] iv, ir, ov, gt, lt, eq, bz;
  logic [7:0] da, db;
  logic       ordy;
  logic [2:0] c4e, c4f;
  logic [3:0] c8;
  logic [0:0] c1;
  logic [3:0] cyc [4];

  assign cyc[0] = {1'b0, c4e};
  assign cyc[1] = {1'b0, c4f};
  assign cyc[2] = c8;
  assign cyc[3] = {3'b000, c1};

  int vectors = 0;
  int miscompares = 0;

  serial_magnitude_comparator #(.WIDTH(4), .EARLY_EXIT(1)) u_w4e (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .data_a(da[3:0]),
    .data_b(db[3:0]), .out_valid(ov[0]), .out_ready(ordy), .greater(gt[0]), .lesser(lt[0]),
    .equal(eq[0]), .busy(bz[0]), .cycles(c4e)
  );
  serial_magnitude_comparator #(.WIDTH(4), .EARLY_EXIT(0)) u_w4f (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .data_a(da[3:0]),
    .data_b(db[3:0]), .out_valid(ov[1]), .out_ready(ordy), .greater(gt[1]), .lesser(lt[1]),
    .equal(eq[1]), .busy(bz[1]), .cycles(c4f)
  );
  serial_magnitude_comparator #(.WIDTH(8), .EARLY_EXIT(0)) u_w8f (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .data_a(da),
    .data_b(db), .out_valid(ov[2]), .out_ready(ordy), .greater(gt[2]), .lesser(lt[2]),
    .equal(eq[2]), .busy(bz[2]), .cycles(c8)
  );
  serial_magnitude_comparator #(.WIDTH(1), .EARLY_EXIT(1)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir[3]), .data_a(da[0:0]),
    .data_b(db[0:0]), .out_valid(ov[3]), .out_ready(ordy), .greater(gt[3]), .lesser(lt[3]),
    .equal(eq[3]), .busy(bz[3]), .cycles(c1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scan length: WIDTH - (index of highest differing bit) with early exit, else WIDTH.
  function automatic int n_of(input int w, input int early, input int a, input int b);
    if (early == 0 || a == b) return w;
    for (int p = w - 1; p >= 0; p--) if (a[p] != b[p]) return w - p;
    return w;
  endfunction

  task automatic accept(input int inst, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    da = a;
    db = b;
    iv[inst] = 1'b1;
    chk("accept_in_ready", {31'd0, ir[inst]}, 1);
    @(posedge clk);
    #1 iv[inst] = 1'b0;
  endtask

  task automatic collect(input int inst, input logic g, input logic l, input logic e,
                         input int ecyc, input int stall, input bit drain);
    int lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (ov[inst] !== 1'b1 && lat < 40);
    chk("latency", lat, ecyc + 1);
    if (ov[inst] !== 1'b1) begin
      chk("out_valid_timeout", {31'd0, ov[inst]}, 1);
      return;
    end
    chk("greater", {31'd0, gt[inst]}, {31'd0, g});
    chk("lesser", {31'd0, lt[inst]}, {31'd0, l});
    chk("equal", {31'd0, eq[inst]}, {31'd0, e});
    chk("cycles", {28'd0, cyc[inst]}, ecyc);
    chk("done_in_ready", {31'd0, ir[inst]}, 0);
    chk("done_busy", {31'd0, bz[inst]}, 1);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, ov[inst]}, 1);
      chk("hold_flags", {29'd0, gt[inst], lt[inst], eq[inst]}, {29'd0, g, l, e});
      chk("hold_cycles", {28'd0, cyc[inst]}, ecyc);
    end
    if (!drain) return;
    ordy = 1'b1;
    @(posedge clk);
    #1 ordy = 1'b0;
    chk("drain_valid", {31'd0, ov[inst]}, 0);
    chk("drain_flags", {29'd0, gt[inst], lt[inst], eq[inst]}, 0);
    chk("drain_in_ready", {31'd0, ir[inst]}, 1);
  endtask

  initial begin
    rst  = 1'b0;
    iv   = '0;
    ordy = 1'b0;
    da   = '0;
    db   = '0;
    #1 rst = 1'b1;
    #2;
    chk("rst_in_ready", {28'd0, ir}, 32'hF);
    chk("rst_out_valid", {28'd0, ov}, 0);
    chk("rst_flags", {20'd0, gt, lt, eq}, 0);
    chk("rst_busy", {28'd0, bz}, 0);
    chk("rst_cycles", {28'd0, cyc[0] | cyc[1] | cyc[2] | cyc[3]}, 0);
    @(negedge clk);
    rst = 1'b0;

    // W4 early exit: differ at MSB, then equal operands take the full scan.
    accept(0, 8'h05, 8'h0A);
    collect(0, 1'b0, 1'b1, 1'b0, 1, 0, 1'b1);
    accept(0, 8'h0F, 8'h0F);
    collect(0, 1'b0, 1'b0, 1'b1, 4, 0, 1'b1);
    accept(0, 8'h00, 8'h00);
    collect(0, 1'b0, 1'b0, 1'b1, 4, 1, 1'b1);
    // W4 full scan: decision at MSB, later bits ignored.
    accept(1, 8'h0C, 8'h04);
    collect(1, 1'b1, 1'b0, 1'b0, 4, 0, 1'b1);

    // Backpressure with a competing pair presented throughout scan and DONE.
    accept(0, 8'h09, 8'h08);
    da = 8'h03;
    db = 8'h04;
    iv[0] = 1'b1;
    collect(0, 1'b1, 1'b0, 1'b0, 4, 5, 1'b0);
    chk("bp_in_ready", {31'd0, ir[0]}, 0);
    ordy = 1'b1;
    @(posedge clk);
    #1 ordy = 1'b0;
    chk("bp_drain_valid", {31'd0, ov[0]}, 0);
    chk("bp_in_ready_after", {31'd0, ir[0]}, 1);
    @(posedge clk);
    #1 iv[0] = 1'b0;
    collect(0, 1'b0, 1'b1, 1'b0, 2, 0, 1'b1);

    // Reset in SCAN cycle 3 of the W8 unit; new pair offered as reset deasserts.
    accept(2, 8'hAA, 8'h55);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("w8_busy_scan", {31'd0, bz[2]}, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", {31'd0, ov[2]}, 0);
    chk("mid_rst_busy", {31'd0, bz[2]}, 0);
    chk("mid_rst_in_ready", {31'd0, ir[2]}, 1);
    chk("mid_rst_cycles", {28'd0, cyc[2]}, 0);
    @(negedge clk);
    rst = 1'b0;
    da = 8'h80;
    db = 8'h7F;
    iv[2] = 1'b1;
    @(posedge clk);
    #1 iv[2] = 1'b0;
    collect(2, 1'b1, 1'b0, 1'b0, 8, 1, 1'b1);

    // W1 corners.
    accept(3, 8'h00, 8'h00);
    collect(3, 1'b0, 1'b0, 1'b1, 1, 0, 1'b1);
    accept(3, 8'h00, 8'h01);
    collect(3, 1'b0, 1'b1, 1'b0, 1, 0, 1'b1);
    accept(3, 8'h01, 8'h00);
    collect(3, 1'b1, 1'b0, 1'b0, 1, 0, 1'b1);
    accept(3, 8'h01, 8'h01);
    collect(3, 1'b0, 1'b0, 1'b1, 1, 0, 1'b1);

    // Exhaustive W4 for both scan modes with random output stalls.
    for (int inst = 0; inst < 2; inst++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          accept(inst, 8'(a), 8'(b));
          collect(inst, a > b, a < b, a == b, n_of(4, (inst == 0) ? 1 : 0, a, b),
                  int'($urandom_range(0, 3)), 1'b1);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_magnitude_comparator.md
# serial_magnitude_comparator

Sequential, bit-serial unsigned magnitude comparator for two WIDTH-bit operands. It accepts a parallel operand pair over a valid/ready handshake. It then scans the operands MSB-first, one bit per clock, through a single-bit greater/lesser/equal compare stage. It returns one-hot result flags over a second valid/ready handshake. It sits upstream of any consumer of greater/lesser/equal flags and extends the single-bit comparator to arbitrary width at one bit-slice of logic.

## Interface
- WIDTH, 4: operand width in bits; legal range WIDTH >= 1.
- EARLY_EXIT, 1: 1 = stop scanning at the first differing bit; 0 = always scan all WIDTH bits.
- clk  input  1  rising-edge clock.
- rst  input  1  reset; one clock, asynchronous, active-high.
- in_valid  input  1  operand pair on data_a/data_b is valid.
- in_ready  output  1  block can accept an operand pair.
- data_a  input  WIDTH  operand A, unsigned.
- data_b  input  WIDTH  operand B, unsigned.
- out_valid  output  1  result flags valid.
- out_ready  input  1  consumer takes the result.
- greater  output  1  A > B.
- lesser  output  1  A < B.
- equal  output  1  A == B.
- busy  output  1  high in SCAN or DONE.
- cycles  output  $clog2(WIDTH+1)  number of bit-compare cycles used for the current result.

## Operation
- The FSM has three states: IDLE, SCAN and DONE. Reset and power-up go to IDLE.
- **IDLE**
  - in_ready = 1.
  - When in_valid is high, data_a/data_b are captured into shift registers, cycles is cleared, the bit counter is set to WIDTH-1, and the FSM moves to SCAN.
- **SCAN**
  - The 1-bit compare uses MSB a_bit, b_bit of the shift registers: lesser_bit = ~a_bit & b_bit, greater_bit = a_bit & ~b_bit.
  - cycles increments each SCAN cycle.
  - Both shift registers shift left by one each cycle.
  - The first differing bit latches the result: greater or lesser.
    - EARLY_EXIT=1: go to DONE at once.
    - EARLY_EXIT=0: later bits are ignored and scanning continues to bit 0.
  - After the bit-0 compare, go to DONE. If no bit differed, the result is equal.
- **DONE**
  - out_valid = 1 and exactly one of greater/lesser/equal is high.
  - Flags and cycles are held stable while out_ready is low.
  - When out_valid and out_ready are both high, clear the flags and go to IDLE.
- busy = (state != IDLE). in_ready = (state == IDLE).
- data_a/data_b are sampled only at accept; later changes have no effect.
- in_valid is ignored in SCAN and DONE, so no transaction is queued or lost-accepted.
- Arithmetic is unsigned only. The bit counter wraps nowhere, because the FSM exits at count 0.
- Reset values:
  - state = IDLE, in_ready = 1.
  - out_valid, greater, lesser, equal and busy = 0.
  - cycles = 0.
  - Shift registers = 0.

## Timing
- in_ready and busy are decoded combinationally from state. All other outputs come straight from registers.
- Cycle 0 is the accept cycle: in_valid & in_ready high at its closing edge.
- SCAN occupies cycles 1..n:
  - EARLY_EXIT=1: n = WIDTH − p, where p is the index of the highest differing bit. n = WIDTH if the operands are equal.
  - EARLY_EXIT=0: n = WIDTH always.
- out_valid rises in cycle n+1. cycles = n while out_valid is high.
- Minimum transaction period, with out_ready held high: n+2 cycles. There is no back-to-back accept from DONE.
- Reset mid-SCAN or mid-DONE:
  - All outputs drop to their reset values immediately, asynchronously.
  - The pending result is discarded and no out_valid is produced.
  - The first edge after rst deasserts can accept new operands.
- Special cases:
  - WIDTH=1: n = 1 always.
  - in_valid high in the same cycle reset deasserts: accepted at that edge.

## Test plan
- WIDTH=4, EARLY_EXIT=1, a=0101, b=1010 -> lesser=1, greater=0, equal=0, cycles=1, out_valid in cycle 2 after accept.
- WIDTH=4, a=b=1111; repeat with a=b=0000 -> equal=1, cycles=4, out_valid in cycle 5. Then EARLY_EXIT=0 with a=1100, b=0100 -> greater=1, cycles=4.
- Backpressure: a=1001, b=1000, out_ready low for 5 cycles in DONE -> greater=1, cycles=4, held stable; in_ready=0. A new in_valid pair presented during this time is not accepted. After out_ready is pulsed, in_ready=1 the next cycle and the new pair completes correctly.
- Reset mid-operation: WIDTH=8, EARLY_EXIT=0, assert rst in SCAN cycle 3 -> out_valid=0, busy=0, in_ready=1, cycles=0 with no clock edge needed. Next pair a=0x80, b=0x7F -> greater=1, cycles=8.
- Exhaustive: WIDTH=4, all 256 (a,b) pairs for each EARLY_EXIT value, random out_ready stalls -> flags match a>b / a<b / a==b and are one-hot; cycles matches the n formula.
- WIDTH=1 corners (0/0, 0/1, 1/0, 1/1) -> equal, lesser, greater, equal, each with cycles=1.
